// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle sequencer and the datapath/memory.
// The master side is the sequencer: it consumes opcode/mem_ready and drives every strobe.
interface multicycle_control_fsm_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pcWrite;
  logic                pcWriteCond;
  logic                memGetData;
  logic                memRead;
  logic [1:0]          regWriteDataSelect;
  logic                irWrite;
  logic                regWrite;
  logic                aluSrcA;
  logic [1:0]          aluSrcB;
  logic [ALUOP_W-1:0]  aluOP;
  logic [1:0]          pcSrc;
  logic                regTrackSelect;
  logic [3:0]          state_out;
  logic                instr_done;
  logic                halted;
  logic                error;

  modport master (
    input  opcode, mem_ready,
    output pcWrite, pcWriteCond, memGetData, memRead, regWriteDataSelect, irWrite,
           regWrite, aluSrcA, aluSrcB, aluOP, pcSrc, regTrackSelect, state_out,
           instr_done, halted, error
  );

  modport slave (
    output opcode, mem_ready,
    input  pcWrite, pcWriteCond, memGetData, memRead, regWriteDataSelect, irWrite,
           regWrite, aluSrcA, aluSrcB, aluOP, pcSrc, regTrackSelect, state_out,
           instr_done, halted, error
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: state register, memory wait-state timeout, and per-state
// decode of datapath strobes. HALT and ERROR are terminal until reset.
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    REG_FETCH = 4'd1,
    IMM2      = 4'd2,
    ALU_R3    = 4'd3,
    ALU_RI3   = 4'd4,
    ALU4      = 4'd5,
    BRANCH3   = 4'd6,
    MEM3      = 4'd7,
    LOAD4     = 4'd8,
    STORE4    = 4'd9,
    LOAD5     = 4'd10,
    JUMP3     = 4'd11,
    HALT      = 4'd12,
    ERROR     = 4'd13
  } stateT;

  localparam logic [7:0]          WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam logic [OPCODE_W-4:0] LOW_JUMP   = {(OPCODE_W-3){1'b0}};
  localparam logic [OPCODE_W-4:0] LOW_IMM    = {{(OPCODE_W-4){1'b0}}, 1'b1};

  stateT                stateReg;
  stateT                nextState;
  logic [7:0]           waitCnt;
  logic [3:0]           opcReg;
  logic [2:0]           header;
  logic [OPCODE_W-4:0]  opLow;
  logic                 inWait;
  logic                 timeout;

  assign header  = bus.opcode[OPCODE_W-1 -: 3];
  assign opLow   = bus.opcode[OPCODE_W-4:0];
  assign inWait  = (stateReg == FETCH) || (stateReg == LOAD4) || (stateReg == STORE4);
  assign timeout = (waitCnt == WAIT_LIMIT) && !bus.mem_ready;
  assign bus.state_out = stateReg;

  // Next-state selection and strobe decode; reset forces every strobe to its idle value.
  always_comb begin
    nextState              = stateReg;
    bus.pcWrite            = 1'b0;
    bus.pcWriteCond        = 1'b0;
    bus.memGetData         = 1'b0;
    bus.memRead            = 1'b1;
    bus.regWriteDataSelect = 2'd0;
    bus.irWrite            = 1'b0;
    bus.regWrite           = 1'b0;
    bus.aluSrcA            = 1'b0;
    bus.aluSrcB            = 2'd0;
    bus.aluOP              = {ALUOP_W{1'b0}};
    bus.pcSrc              = 2'd0;
    bus.regTrackSelect     = 1'b0;
    bus.instr_done         = 1'b0;
    bus.halted             = 1'b0;
    bus.error              = 1'b0;
    if (!rst_n) begin
      nextState = FETCH;
    end else begin
      bus.regTrackSelect = (header == 3'b101) || (bus.opcode[OPCODE_W-1 -: 4] == 4'b1001);
      case (stateReg)
        FETCH: begin
          bus.pcSrc = 2'd2;
          if (bus.mem_ready) begin
            bus.pcWrite = 1'b1;
            bus.irWrite = 1'b1;
            nextState   = REG_FETCH;
          end else if (timeout) begin
            nextState = ERROR;
          end else begin
            nextState = FETCH;
          end
        end
        REG_FETCH: begin
          bus.aluSrcB = 2'd2;
          case (header)
            3'b000, 3'b001: nextState = ALU_R3;
            3'b010, 3'b011: nextState = ALU_RI3;
            3'b100:         nextState = MEM3;
            3'b101:         nextState = BRANCH3;
            3'b110: begin
              if (opLow == LOW_JUMP) begin
                nextState = JUMP3;
              end else if (opLow == LOW_IMM) begin
                nextState = IMM2;
              end else begin
                nextState = ERROR;
              end
            end
            3'b111: begin
              if (&bus.opcode) begin
                nextState = HALT;
              end else begin
                nextState = ERROR;
              end
            end
            default: nextState = ERROR;
          endcase
        end
        ALU_R3: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'd1;
          bus.aluOP   = ALUOP_W'(opcReg);
          nextState   = ALU4;
        end
        ALU_RI3: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'd3;
          bus.aluOP   = ALUOP_W'(opcReg);
          nextState   = ALU4;
        end
        ALU4: begin
          bus.regWrite           = 1'b1;
          bus.regWriteDataSelect = 2'd1;
          bus.instr_done         = 1'b1;
          nextState              = FETCH;
        end
        BRANCH3: begin
          bus.pcWriteCond = 1'b1;
          bus.aluSrcA     = 1'b1;
          bus.aluSrcB     = 2'd1;
          bus.aluOP       = ALUOP_W'({1'b1, opcReg[2:0]});
          bus.instr_done  = 1'b1;
          nextState       = FETCH;
        end
        MEM3: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'd3;
          nextState   = opcReg[2] ? STORE4 : LOAD4;
        end
        LOAD4: begin
          bus.memGetData = 1'b1;
          if (bus.mem_ready) begin
            nextState = LOAD5;
          end else if (timeout) begin
            nextState = ERROR;
          end else begin
            nextState = LOAD4;
          end
        end
        STORE4: begin
          bus.memGetData = 1'b1;
          bus.memRead    = 1'b0;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            nextState      = FETCH;
          end else if (timeout) begin
            nextState = ERROR;
          end else begin
            nextState = STORE4;
          end
        end
        LOAD5: begin
          bus.regWrite           = 1'b1;
          bus.regWriteDataSelect = 2'd0;
          bus.instr_done         = 1'b1;
          nextState              = FETCH;
        end
        JUMP3: begin
          bus.pcWrite    = 1'b1;
          bus.pcSrc      = 2'd1;
          bus.instr_done = 1'b1;
          nextState      = FETCH;
        end
        IMM2: begin
          bus.regWrite           = 1'b1;
          bus.regWriteDataSelect = 2'd2;
          bus.instr_done         = 1'b1;
          nextState              = FETCH;
        end
        HALT: begin
          bus.halted = 1'b1;
          nextState  = HALT;
        end
        ERROR: begin
          bus.error = 1'b1;
          nextState = ERROR;
        end
        default: nextState = ERROR;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= FETCH;
    end else begin
      stateReg <= nextState;
    end
  end

  // Only the ALU-function bits of the opcode are needed after REG_FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcReg <= 4'd0;
    end else if (stateReg == REG_FETCH) begin
      opcReg <= bus.opcode[3:0];
    end else begin
      opcReg <= opcReg;
    end
  end

  // Memory wait counter: runs while a memory state stalls, clears on any state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= 8'd0;
    end else if (inWait && !bus.mem_ready && (nextState == stateReg)) begin
      waitCnt <= waitCnt + 8'd1;
    end else begin
      waitCnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised bench: each instruction is expanded into its expected per-cycle step list
// (state plus strobes) from the opcode class and chosen memory latencies, then replayed.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 16;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       pcW, pcWC, mGD, mRd, rW, irW, aSA, done, hlt, err;
    logic [1:0] rWDS, aSB, pcS;
    logic [3:0] aop;
  } stepT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  stepT plan[$];
  logic [5:0] curOpc = 6'd0;

  multicycle_control_fsm_if #(.OPCODE_W(6), .ALUOP_W(4)) bus ();

  multicycle_control_fsm #(.OPCODE_W(6), .ALUOP_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stepT mk(input logic [3:0] st);
    stepT s;
    s.st = st; s.rdy = 1'($urandom % 2);
    s.pcW = 1'b0; s.pcWC = 1'b0; s.mGD = 1'b0; s.mRd = 1'b1; s.rW = 1'b0; s.irW = 1'b0;
    s.aSA = 1'b0; s.done = 1'b0; s.hlt = (st == 4'd12); s.err = (st == 4'd13);
    s.rWDS = 2'd0; s.aSB = 2'd0; s.pcS = 2'd0; s.aop = 4'd0;
    return s;
  endfunction

  function automatic logic [23:0] packS(input stepT s);
    return {s.st, s.pcW, s.pcWC, s.mGD, s.mRd, s.rW, s.irW, s.aSA, s.done, s.hlt, s.err,
            s.rWDS, s.aSB, s.pcS, s.aop};
  endfunction

  function automatic logic [23:0] obsVec();
    return {bus.state_out, bus.pcWrite, bus.pcWriteCond, bus.memGetData, bus.memRead,
            bus.regWrite, bus.irWrite, bus.aluSrcA, bus.instr_done, bus.halted, bus.error,
            bus.regWriteDataSelect, bus.aluSrcB, bus.pcSrc, bus.aluOP};
  endfunction

  // A memory phase: 'waits' stalled cycles, then either completion or timeout into ERROR.
  task automatic pushWait(input stepT base, input stepT doneStep, input int waits, input bit expire);
    stepT s;
    for (int i = 0; i < waits; i++) begin
      s = base; s.rdy = 1'b0; plan.push_back(s);
    end
    if (expire) begin
      for (int i = 0; i < 3; i++) plan.push_back(mk(4'd13));
    end else begin
      s = doneStep; s.rdy = 1'b1; plan.push_back(s);
    end
  endtask

  task automatic pushFetch(input int waits, input bit expire);
    stepT b, d;
    b = mk(4'd0); b.pcS = 2'd2;
    d = b; d.pcW = 1'b1; d.irW = 1'b1;
    pushWait(b, d, waits, expire);
  endtask

  task automatic buildInstr(input logic [5:0] opc, input int fw, input int mw, input bit memExpire);
    stepT s, d;
    logic [2:0] hdr;
    hdr = opc[5:3];
    pushFetch(fw, 1'b0);
    s = mk(4'd1); s.aSB = 2'd2; plan.push_back(s);
    if (hdr <= 3'd3) begin
      s = mk((hdr <= 3'd1) ? 4'd3 : 4'd4);
      s.aSA = 1'b1; s.aSB = (hdr <= 3'd1) ? 2'd1 : 2'd3; s.aop = opc[3:0];
      plan.push_back(s);
      s = mk(4'd5); s.rW = 1'b1; s.rWDS = 2'd1; s.done = 1'b1; plan.push_back(s);
    end else if (hdr == 3'd4) begin
      s = mk(4'd7); s.aSA = 1'b1; s.aSB = 2'd3; plan.push_back(s);
      if (opc[2]) begin
        s = mk(4'd9); s.mGD = 1'b1; s.mRd = 1'b0;
        d = s; d.done = 1'b1;
        pushWait(s, d, mw, memExpire);
      end else begin
        s = mk(4'd8); s.mGD = 1'b1;
        pushWait(s, s, mw, memExpire);
        if (!memExpire) begin
          s = mk(4'd10); s.rW = 1'b1; s.done = 1'b1; plan.push_back(s);
        end
      end
    end else if (hdr == 3'd5) begin
      s = mk(4'd6); s.pcWC = 1'b1; s.aSA = 1'b1; s.aSB = 2'd1; s.aop = {1'b1, opc[2:0]};
      s.done = 1'b1; plan.push_back(s);
    end else if (opc == 6'b110000) begin
      s = mk(4'd11); s.pcW = 1'b1; s.pcS = 2'd1; s.done = 1'b1; plan.push_back(s);
    end else if (opc == 6'b110001) begin
      s = mk(4'd2); s.rW = 1'b1; s.rWDS = 2'd2; s.done = 1'b1; plan.push_back(s);
    end else if (opc == 6'b111111) begin
      for (int i = 0; i < 4; i++) plan.push_back(mk(4'd12));
    end else begin
      for (int i = 0; i < 4; i++) plan.push_back(mk(4'd13));
    end
  endtask

  task automatic runPlan(input string tag, input int maxSteps);
    stepT e;
    logic expRts;
    int n;
    n = 0;
    while (plan.size() > 0 && n < maxSteps) begin
      e = plan.pop_front();
      n++;
      @(negedge clk);
      bus.mem_ready = e.rdy;
      bus.opcode = curOpc;
      #1;
      checks++;
      if (obsVec() !== packS(e)) begin
        failures++;
        $display("FAIL %s step%0d opc=%b: got %h expected %h", tag, n, curOpc, obsVec(), packS(e));
      end
      expRts = (curOpc[5:3] == 3'b101) || (curOpc[5:2] == 4'b1001);
      checks++;
      if (bus.regTrackSelect !== expRts) begin
        failures++;
        $display("FAIL %s regTrackSelect opc=%b: got %b expected %b", tag, curOpc, bus.regTrackSelect, expRts);
      end
    end
    plan.delete();
  endtask

  // Holds reset for two cycles with mem_ready high, checking the idle strobe set, and
  // releases it mid high-phase so the next step starts cleanly in FETCH.
  task automatic test_reset();
    stepT idle;
    idle = mk(4'd0);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'($urandom);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obsVec() !== packS(idle) || bus.regTrackSelect !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: got %h rts=%b expected %h rts=0", obsVec(), bus.regTrackSelect, packS(idle));
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic runInstr(input string tag, input logic [5:0] opc, input int fw, input int mw);
    curOpc = opc;
    buildInstr(opc, fw, mw, 1'b0);
    runPlan(tag, 1000);
  endtask

  task automatic test_alu();
    runInstr("add", 6'b000010, 0, 0);
    runInstr("alu_ri", 6'b010111, 2, 0);
  endtask

  task automatic test_load_store();
    runInstr("lw", 6'b100000, 0, 3);
    runInstr("sw", 6'b100100, 1, 2);
    runInstr("sw_nowait", 6'b100111, 0, 0);
  endtask

  task automatic test_branch_jump();
    runInstr("beq", 6'b101001, 0, 0);
    runInstr("jump", 6'b110000, 0, 0);
    runInstr("imm", 6'b110001, 0, 0);
  endtask

  task automatic test_timeout();
    test_reset();
    curOpc = 6'b000000;
    pushFetch(MEM_TIMEOUT, 1'b1);
    runPlan("fetch_timeout", 1000);
    test_reset();
    runInstr("fetch_ready_last", 6'b000001, MEM_TIMEOUT - 1, 0);
    runInstr("load_ready_last", 6'b100001, 0, MEM_TIMEOUT - 1);
    curOpc = 6'b100100;
    buildInstr(curOpc, 0, MEM_TIMEOUT, 1'b1);
    runPlan("store_timeout", 1000);
    test_reset();
  endtask

  task automatic test_terminal();
    runInstr("halt", 6'b111111, 0, 0);
    test_reset();
    runInstr("illegal_111000", 6'b111000, 0, 0);
    test_reset();
    runInstr("illegal_110010", 6'b110010, 1, 0);
    test_reset();
  endtask

  task automatic test_reset_midinstr();
    curOpc = 6'b100000;
    buildInstr(curOpc, 0, 10, 1'b0);
    runPlan("lw_partial", 5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state_out !== 4'd0 || bus.regWrite !== 1'b0 || bus.pcWrite !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: state=%0d regWrite=%b pcWrite=%b expected 0/0/0",
               bus.state_out, bus.regWrite, bus.pcWrite);
    end
    test_reset();
    runInstr("after_abort", 6'b000011, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] opc;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    opc = 6'($urandom_range(0, 15));
        2:       opc = 6'($urandom_range(16, 31));
        3, 4:    opc = 6'(32 + $urandom_range(0, 7));
        5:       opc = 6'(40 + $urandom_range(0, 7));
        6:       opc = 6'b110000;
        default: opc = 6'b110001;
      endcase
      runInstr("random", opc, $urandom_range(0, MEM_TIMEOUT - 1), $urandom_range(0, MEM_TIMEOUT - 1));
    end
  endtask

  initial begin
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_timeout();
    test_terminal();
    test_reset_midinstr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Next-generation multicycle control unit: owns the state register and sequencer, and decodes the current state into datapath control strobes.
- Replaces the purely combinational per-state decode. Adds memory wait-state handshaking, a wait-state timeout, HALT/ERROR terminal states, an illegal-opcode trap, and parametrised opcode/ALU-op widths.
- Sits between the instruction register (opcode source) and the multicycle datapath/memory.

Parameters:
- OPCODE_W, 6, opcode width; opcode[OPCODE_W-1:OPCODE_W-3] is the class header, low 4 bits select the ALU function.
- ALUOP_W, 4, width of aluOP; must be ≥4.
- MEM_TIMEOUT, 16, maximum wait cycles for any memory state before ERROR; range 2..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  from IR; sampled only in REG_FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load if ALU zero.
- memGetData  out  1  0 = instruction address, 1 = data address (ALUOut).
- memRead  out  1  1 = read, 0 = write.
- regWriteDataSelect  out  2  0 MDR, 1 ALUOut, 2 SE big immediate.
- irWrite  out  1  IR load.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0 PC, 1 busA.
- aluSrcB  out  2  0 const 4, 1 busB, 2 SE shifted offset, 3 SE offset.
- aluOP  out  ALUOP_W  ALU function; ADD = 0.
- pcSrc  out  2  0 ALUOut, 1 jump address, 2 ALU direct.
- regTrackSelect  out  1  1 for branch or store (reads rt as second source).
- state_out  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- halted  out  1  high in HALT.
- error  out  1  high in ERROR.

Behaviour:
- State encodings: FETCH=0, REG_FETCH=1, IMM2=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BRANCH3=6, MEM3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11, HALT=12, ERROR=13. Codes 14–15 go to ERROR.
- Reset (async): state=FETCH, opc register=0, wait counter=0. While rst_n=0 all strobes are 0 except memRead=1; aluOP=0, selects=0, flags 0.
- Outputs are a function of state, latched opc and mem_ready only. Default for every strobe is 0, memRead=1, selects 0.
- FETCH:
  - Drives memGetData=0, aluSrcA=PC, aluSrcB=4, aluOP=ADD, pcSrc=2.
  - pcWrite and irWrite are asserted only in the cycle mem_ready=1.
  - Exits to REG_FETCH on mem_ready; otherwise stays and the wait counter increments.
- REG_FETCH:
  - Drives aluSrcA=PC, aluSrcB=2, aluOP=ADD; latches opc<=opcode.
  - Next state from header h=opcode[5:3] (OPCODE_W=6): h=000/001 → ALU_R3; h=010/011 → ALU_RI3; h=100 → MEM3; h=101 → BRANCH3.
  - 110000 → JUMP3; 110001 → IMM2; 111111 → HALT; anything else → ERROR (illegal).
- ALU_R3: aluSrcA=1, aluSrcB=1, aluOP=opc[3:0] zero-extended → ALU4.
- ALU_RI3: aluSrcA=1, aluSrcB=3, aluOP=opc[3:0] → ALU4.
- ALU4: regWrite=1, regWriteDataSelect=1, instr_done=1 → FETCH.
- BRANCH3: pcWriteCond=1, aluSrcA=1, aluSrcB=1, aluOP={1,opc[2:0]} zero-extended, instr_done=1 → FETCH.
- MEM3: aluSrcA=1, aluSrcB=3, aluOP=ADD → STORE4 if opc[2]=1, else LOAD4.
- LOAD4: memGetData=1, memRead=1. Holds until mem_ready, then → LOAD5.
- STORE4: memGetData=1, memRead=0 for every cycle in the state. On mem_ready: instr_done=1 → FETCH.
- LOAD5: regWrite=1, regWriteDataSelect=0, instr_done=1 → FETCH.
- JUMP3: pcWrite=1, pcSrc=1, instr_done=1 → FETCH.
- IMM2: regWrite=1, regWriteDataSelect=2, instr_done=1 → FETCH.
- Wait counter:
  - Counts cycles spent in FETCH/LOAD4/STORE4 with mem_ready=0; clears on state change.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, next state is ERROR; the access strobes of that cycle are still driven.
  - mem_ready=1 in the timeout cycle wins: normal transition, no error.
- HALT and ERROR are sticky until reset; all strobes idle; halted or error held high.
- regTrackSelect is combinational from the live opcode input: 1 if opcode[5:3]=101, or opcode[5:2]=1001.
- Reset mid-instruction aborts immediately to FETCH with no partial regWrite/pcWrite.

Test Plan:
- add (opcode 000010), mem_ready always 1 → states 0,1,3,5; aluOP=0010 in ALU_R3; regWrite=1, sel=1 in state 5; instr_done pulse; 4 cycles total.
- lw (opcode 100000), mem_ready low 3 cycles in LOAD4 → LOAD4 lasts 4 cycles with memGetData=1; then LOAD5 with regWrite=1, sel=0.
- sw (opcode 100100) → MEM3 then STORE4 with memRead=0; regTrackSelect=1; no regWrite in any cycle.
- beq (opcode 101001) → BRANCH3 with pcWriteCond=1, aluOP=1001. Jump (110000) → JUMP3 with pcWrite=1, pcSrc=1.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=16 → ERROR entered after 16 FETCH cycles, error=1 held. mem_ready=1 on cycle 16 → REG_FETCH, no error.
- opcode 111111 → HALT, halted=1 sticky. opcode 111000 → ERROR. rst_n pulsed low in LOAD4 → state_out=0 asynchronously; no regWrite pulse.
